binary_to_bcd: RTL and testbench
================================

BINARY_TO_BCD -- requirements
Module: binary_to_bcd

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 7, width of the binary input (valid range 1..16).
REQ-002 SHALL have parameter DECIMAL_DIGITS, default 2, number of BCD digits produced (valid range 1..4).
REQ-003 SHALL have port i_Clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_Start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port i_Binary  input  INPUT_WIDTH  unsigned value to convert, sampled on the same edge as i_Start.
REQ-007 SHALL have port o_BCD  output  4*DECIMAL_DIGITS  packed BCD result, least-significant digit in bits [3:0], held until the next completion.
REQ-008 SHALL have port o_Busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port o_Done  output  1  single-cycle pulse marking o_BCD update.
REQ-010 SHALL have port o_Overflow  output  1  high when the last converted value exceeded 10^DECIMAL_DIGITS-1; held with o_BCD.

Function
REQ-011 SHALL implement an iterative shift-and-add-3 (double dabble) converter with states IDLE, ADD, SHIFT.
REQ-012 SHALL, in IDLE with i_Start=1, capture i_Binary into an internal shift register, clear the BCD accumulator and bit counter, set o_Busy=1, and go to ADD.
REQ-013 SHALL, in ADD, add 3 to every accumulator digit whose value is >=5 (all digits evaluated in parallel, one cycle), then go to SHIFT.
REQ-014 SHALL, in SHIFT, left-shift {accumulator, shift register} by one bit and increment the bit counter; go to ADD if fewer than INPUT_WIDTH shifts are complete, else complete.
REQ-015 SHALL, on the completing SHIFT edge, load o_BCD with the final accumulator, set o_Done=1 for exactly one cycle, clear o_Busy, and return to IDLE.
REQ-016 SHALL have fixed latency: o_Done high in the cycle beginning 2*INPUT_WIDTH rising edges after the edge that sampled i_Start (14 for defaults), independent of input value.
REQ-017 SHALL ignore i_Start and i_Binary while o_Busy=1; no queuing, no restart.
REQ-018 SHALL accept a new i_Start in the same cycle o_Done is high (back-to-back, one conversion per 2*INPUT_WIDTH cycles).
REQ-019 SHALL compare the captured input against 10^DECIMAL_DIGITS-1 (elaboration-time constant) at start; if greater, on completion o_BCD SHALL be all nibbles 4'hF (blanks downstream 7-segment decoders) and o_Overflow=1, with unchanged latency.
REQ-020 SHALL set o_Overflow=0 on every non-overflow completion; o_BCD and o_Overflow SHALL change only on completion edges or reset.
REQ-021 SHALL size the bit counter to hold INPUT_WIDTH without wrap; the accumulator SHALL be exactly 4*DECIMAL_DIGITS bits, bits shifted beyond it discarded (covered by REQ-019).
REQ-022 SHALL keep o_BCD stable during a conversion (intermediate accumulator values never visible).

Reset
REQ-023 SHALL, on i_Clk edge with i_Reset=1, set state IDLE, o_BCD=0, o_Busy=0, o_Done=0, o_Overflow=0, clear counter and internal registers.
REQ-024 SHALL let reset take priority over i_Start and abort any conversion in progress with no o_Done pulse.
REQ-025 SHALL accept i_Start on the first edge after i_Reset deasserts.

Verification
REQ-026 Reset, then i_Binary=59, i_Start pulse -> o_Busy=1 next cycle; o_Done pulse 14 edges later with o_BCD=8'h59, o_Overflow=0.
REQ-027 Sweep i_Binary 0..99 -> o_BCD equals decimal digits of input for every value (0 -> 8'h00, 99 -> 8'h99), latency 14 each.
REQ-028 i_Binary=100 and 127 -> o_BCD=8'hFF, o_Overflow=1; following conversion of 7 -> 8'h07, o_Overflow=0.
REQ-029 i_Start=1 with i_Binary=12 held during conversion of 45 -> single o_Done, o_BCD=8'h45; then i_Start in Done cycle with 12 -> next o_Done exactly 14 edges later, 8'h12.
REQ-030 i_Reset asserted 6 cycles into conversion of 88 -> all outputs 0 next cycle, no o_Done; new start with 3 -> o_BCD=8'h03 after 14 edges.

Source files
------------

// File: rtl/binary_to_bcd.sv
// -----------------------------------------------------------------------------
// binary_to_bcd
//   Iterative shift-and-add-3 (double dabble) binary to packed-BCD converter.
//   One input bit is consumed every two cycles (ADD then SHIFT), so a
//   conversion takes a fixed 2*INPUT_WIDTH cycles, whatever the input value.
//
// Parameters
//   INPUT_WIDTH    : width of the unsigned binary input (1..16)
//   DECIMAL_DIGITS : number of BCD digits produced (1..4)
//
// Ports
//   i_Clk      : system clock, rising edge
//   i_Reset    : synchronous active-high reset; aborts any conversion
//   i_Start    : conversion request, only looked at while idle
//   i_Binary   : value to convert, captured together with i_Start
//   o_BCD      : packed BCD result, digit 0 in [3:0]; held until next completion
//   o_Busy     : conversion in progress
//   o_Done     : one-cycle pulse on the cycle o_BCD is updated
//   o_Overflow : last converted value did not fit in DECIMAL_DIGITS digits
// -----------------------------------------------------------------------------

// Per-digit correction: a digit of 5..9 becomes >= 8 so that the following
// left shift carries into the next decade.
module binary_to_bcd_digit (
  input  logic [3:0] i_Digit,
  output logic [3:0] o_Digit
);
  assign o_Digit = (i_Digit >= 4'd5) ? (i_Digit + 4'd3) : i_Digit;
endmodule

module binary_to_bcd #(
  parameter int INPUT_WIDTH    = 7,
  parameter int DECIMAL_DIGITS = 2
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Start,
  input  logic [INPUT_WIDTH-1:0]      i_Binary,
  output logic [4*DECIMAL_DIGITS-1:0] o_BCD,
  output logic                        o_Busy,
  output logic                        o_Done,
  output logic                        o_Overflow
);

  localparam int ACC_W = 4*DECIMAL_DIGITS;
  localparam int CAT_W = ACC_W + INPUT_WIDTH;
  // Counter must hold INPUT_WIDTH itself without wrapping.
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

  // Largest value representable in DECIMAL_DIGITS decimal digits.
  localparam logic [31:0] MAX_DEC = 32'(10**DECIMAL_DIGITS - 1);
  // Counter value seen during the SHIFT that completes the conversion.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [1:0]                          r_State;
  logic [INPUT_WIDTH-1:0]              r_Shift;
  logic [DECIMAL_DIGITS-1:0][3:0]      r_Acc;
  logic [CNT_W-1:0]                    r_Cnt;
  logic                                r_Ovf_Pend;
  logic [ACC_W-1:0]                    r_BCD;
  logic                                r_Busy;
  logic                                r_Done;
  logic                                r_Ovf;

  logic [DECIMAL_DIGITS-1:0][3:0]      w_Adj;
  logic [CAT_W-1:0]                    w_Cat;
  logic                                w_Last;
  logic                                w_Too_Big;

  // All digits are corrected in parallel in the ADD cycle.
  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_dig
    binary_to_bcd_digit u_dig (
      .i_Digit (r_Acc[g]),
      .o_Digit (w_Adj[g])
    );
  end

  // {accumulator, shift register} moved left by one; the top accumulator bit
  // falls off, which only matters for values already flagged as overflow.
  assign w_Cat     = {r_Acc, r_Shift} << 1;
  assign w_Last    = (r_Cnt == LAST_CNT);
  assign w_Too_Big = (32'(i_Binary) > MAX_DEC);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State    <= S_IDLE;
      r_Shift    <= '0;
      r_Acc      <= '0;
      r_Cnt      <= '0;
      r_Ovf_Pend <= 1'b0;
      r_BCD      <= '0;
      r_Busy     <= 1'b0;
      r_Done     <= 1'b0;
      r_Ovf      <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      case (r_State)
        S_IDLE: begin
          // Also reached in the o_Done cycle, giving back-to-back conversions.
          if (i_Start) begin
            r_Shift    <= i_Binary;
            r_Acc      <= '0;
            r_Cnt      <= '0;
            r_Ovf_Pend <= w_Too_Big;
            r_Busy     <= 1'b1;
            r_State    <= S_ADD;
          end
        end
        S_ADD: begin
          r_Acc   <= w_Adj;
          r_State <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_Acc, r_Shift} <= w_Cat;
          r_Cnt            <= r_Cnt + CNT_W'(1);
          if (w_Last) begin
            // Overflowed values are blanked to all-F nibbles.
            r_BCD   <= r_Ovf_Pend ? '1 : w_Cat[CAT_W-1:INPUT_WIDTH];
            r_Ovf   <= r_Ovf_Pend;
            r_Done  <= 1'b1;
            r_Busy  <= 1'b0;
            r_State <= S_IDLE;
          end else begin
            r_State <= S_ADD;
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_BCD      = r_BCD;
  assign o_Busy     = r_Busy;
  assign o_Done     = r_Done;
  assign o_Overflow = r_Ovf;

endmodule

// File: tb/tb_binary_to_bcd.sv
module tb_binary_to_bcd;

  localparam int W   = 7;
  localparam int D   = 2;
  localparam int LAT = 2*W;

  logic           i_Clk = 1'b0;
  logic           i_Reset = 1'b1;
  logic           i_Start = 1'b0;
  logic [W-1:0]   i_Binary = '0;
  logic [4*D-1:0] o_BCD;
  logic           o_Busy;
  logic           o_Done;
  logic           o_Overflow;

  binary_to_bcd #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(D)) dut (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Start    (i_Start),
    .i_Binary   (i_Binary),
    .o_BCD      (o_BCD),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Overflow (o_Overflow)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] bcd;
    logic       ovf;
    int         t0;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [7:0] last_bcd = 8'h00;
  logic       last_ovf = 1'b0;

  function automatic logic [7:0] model_bcd(input int v);
    if (v > 99) return 8'hFF;
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Scoreboard: pop on every o_Done, and check outputs hold while busy.
  always @(negedge i_Clk) begin
    if (!i_Reset) begin
      if (o_Done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(o_Done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("bcd", 32'(o_BCD), 32'(e.bcd));
          chk("ovf", 32'(o_Overflow), 32'(e.ovf));
          chk("latency", 32'(cyc - e.t0), 32'(LAT));
          chk("busy_clr", 32'(o_Busy), 32'd0);
          last_bcd = e.bcd;
          last_ovf = e.ovf;
        end
      end else if (o_Busy) begin
        chk("bcd_hold", 32'(o_BCD), 32'(last_bcd));
        chk("ovf_hold", 32'(o_Overflow), 32'(last_ovf));
      end
    end
  end

  // Completes the accepting edge of a start already driven on i_Start.
  task automatic accept(input int v);
    exp_t x;
    @(posedge i_Clk);
    #1;
    x.bcd = model_bcd(v);
    x.ovf = (v > 99);
    x.t0  = cyc;
    sb.push_back(x);
    i_Start = 1'b0;
    chk("busy_set", 32'(o_Busy), 32'd1);
  endtask

  task automatic issue(input int v);
    @(negedge i_Clk);
    i_Start  = 1'b1;
    i_Binary = W'(v);
    accept(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 3*LAT) begin
      @(negedge i_Clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic conv(input int v);
    issue(v);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_bcd",  32'(o_BCD), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_done", 32'(o_Done), 32'd0);
    chk("rst_ovf",  32'(o_Overflow), 32'd0);

    // Start on the first edge after reset release, value 59
    @(negedge i_Clk);
    i_Reset  = 1'b0;
    i_Start  = 1'b1;
    i_Binary = W'(59);
    accept(59);
    wait_idle();

    // Full in-range sweep
    for (int v = 0; v < 100; v++) conv(v);

    // Overflow and recovery
    conv(100);
    conv(127);
    conv(7);

    // Start held during a conversion is ignored; taken again in the Done cycle
    issue(45);
    @(negedge i_Clk);
    i_Start  = 1'b1;
    i_Binary = W'(12);
    begin
      int n = 0;
      while (sb.size() != 0 && n < 3*LAT) begin
        @(negedge i_Clk);
        #1;
        n++;
      end
      chk("b2b_done_seen", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    accept(12);
    wait_idle();

    // Reset aborts a conversion in progress
    issue(88);
    repeat (5) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b1;
    @(posedge i_Clk);
    #1;
    chk("abort_bcd",  32'(o_BCD), 32'd0);
    chk("abort_busy", 32'(o_Busy), 32'd0);
    chk("abort_done", 32'(o_Done), 32'd0);
    chk("abort_ovf",  32'(o_Overflow), 32'd0);
    sb.delete();
    last_bcd = 8'h00;
    last_ovf = 1'b0;
    @(negedge i_Clk);
    i_Reset  = 1'b0;
    i_Start  = 1'b1;
    i_Binary = W'(3);
    accept(3);
    wait_idle();

    // A few random values across the whole input range
    for (int k = 0; k < 12; k++) conv(int'($urandom_range(0, 127)));

    repeat (20) @(posedge i_Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
